hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline, sitting between the ID stage and the ID/EXE pipeline register. It detects RAW hazards against the EXE and MEM destinations and produces registered forwarding selects for the EXE stage. It also stretches load-use stalls over a configurable number of cycles, freezes the whole pipeline while data memory is not ready, and squashes stalls on taken branches. A saturating stall-cycle counter supports performance measurement.

## Interface

Parameters:
- ADDR_W, 5, register-address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal 1..7.
- ZERO_REG_EN, 1, when 1, register 0 never creates a hazard or a forward.

Ports (clock and reset first):
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src1  in  ADDR_W  first source register of the instruction in ID.
- src2  in  ADDR_W  second source register of the instruction in ID.
- two_src  in  1  1 = instruction reads src2; 0 = immediate form, src2 ignored.
- exe_dst  in  ADDR_W  destination of the instruction in EXE.
- mem_dst  in  ADDR_W  destination of the instruction in MEM.
- exe_wb_en  in  1  EXE instruction writes the register file.
- mem_wb_en  in  1  MEM instruction writes the register file.
- exe_mem_read  in  1  EXE instruction is a load.
- fw_en  in  1  forwarding enabled.
- mem_ready  in  1  data memory ready; 0 freezes the pipeline.
- branch_taken  in  1  taken branch resolved this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EXE control fields.
- flush  out  1  zero IF/ID.
- freeze  out  1  hold every pipeline register.
- fwd_a  out  2  EXE operand A select: 00 regfile, 01 EXE/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EXE operand B select, same encoding.
- stall_cycles  out  16  saturating count of cycles with stall=1.

## Operation

- Per-source match: m(s,d) = (s==d) && !(ZERO_REG_EN && d==0). src2 terms are additionally gated by two_src.
- raw_exe = exe_wb_en && (m(src1,exe_dst) || m(src2,exe_dst)).
- raw_mem = mem_wb_en && (m(src1,mem_dst) || m(src2,mem_dst)).
- fw_en=0: hz = raw_exe || raw_mem. This is evaluated every cycle with no FSM involvement.
- fw_en=1: hz = load_use || (state==LOAD_WAIT), where load_use = exe_mem_read && raw_exe.
- FSM states are IDLE and LOAD_WAIT, with a 3-bit counter cnt.
  - IDLE -> LOAD_WAIT when fw_en && load_use && LOAD_STALL>1. On entry, cnt = LOAD_STALL-2.
  - LOAD_WAIT: cnt decrements each advancing cycle. It returns to IDLE when cnt==0.
  - With LOAD_STALL=1 the FSM never leaves IDLE.
- Output priority, highest first:
  - freeze = !mem_ready. When freeze=1: stall=bubble=flush=0, and the FSM, cnt, fwd registers and stall_cycles all hold.
  - branch_taken: flush=1, stall=0, bubble=1. FSM forced to IDLE, aborting any LOAD_WAIT.
  - hz: stall=1, bubble=1.
  - Otherwise all three are 0.
- Forward compute, per operand, with EXE priority over MEM:
  - 01 if exe_wb_en && m(src,exe_dst) && !exe_mem_read.
  - else 10 if mem_wb_en && m(src,mem_dst).
  - else 00.
  - fwd_b is forced to 00 when two_src=0.
  - All forwards are forced to 00 when fw_en=0.
- fwd_a and fwd_b are registers loaded on advancing edges (freeze=0). They load 00 when bubble=1, otherwise the computed value.
- stall_cycles increments on an edge where stall=1, and saturates at 0xFFFF.

## Timing

- Reset: state IDLE, cnt=0, fwd_a=fwd_b=00, stall_cycles=0. While rst=1, stall, bubble, flush and freeze are forced to 0.
- stall, bubble, flush and freeze are combinational from the inputs and state, in the same cycle.
- fwd_a and fwd_b have 1-cycle latency: they are computed while the instruction is in ID and are valid while it is in EXE.
- A load-use hazard holds stall=1 for exactly LOAD_STALL advancing cycles. Frozen cycles do not count toward that total.
- A branch arriving on the same cycle as a load_use wins: no stall and no counter increment.
- Reset asserted mid-LOAD_WAIT clears the state immediately, asynchronously.
- mem_ready falling mid-LOAD_WAIT holds cnt. The remaining stall cycles resume when mem_ready returns.

## Test plan

- fw_en=0, src1=3, exe_dst=3, exe_wb_en=1 -> stall=bubble=1 that cycle. With src1=0 (ZERO_REG_EN=1) -> stall=0.
- fw_en=1, LOAD_STALL=3, load to r5 in EXE, src2=5, two_src=1 -> stall=1 for 3 consecutive cycles, then 0. stall_cycles reads 3.
- fw_en=1, exe_dst=4 (no load), mem_dst=4, both wb_en, src1=4 -> next cycle fwd_a=01. Same with exe_wb_en=0 -> fwd_a=10.
- two_src=0, src2=exe_dst=7, exe_wb_en=1, fw_en=0 -> stall=0. With fw_en=1 -> fwd_b=00.
- LOAD_STALL=4, branch_taken=1 in 2nd stall cycle -> flush=1, stall=0, FSM returns to IDLE. Next cycle stall=0.
- mem_ready=0 for 5 cycles during LOAD_WAIT (LOAD_STALL=3) -> freeze=1 and stall=0 throughout. After release, the remaining stall cycles complete, for 3 stall cycles in total.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if
// Bundles the ID/EXE/MEM hazard-detection inputs and the stall/forward
// outputs of hazard_forward_unit.
//   master : pipeline side, drives register addresses and status, reads controls
//   slave  : hazard_forward_unit, reads pipeline status, drives controls
// Ports carried: src1, src2, two_src, exe_dst, mem_dst, exe_wb_en, mem_wb_en,
//   exe_mem_read, fw_en, mem_ready, branch_taken (to unit);
//   stall, bubble, flush, freeze, fwd_a, fwd_b, stall_cycles (from unit).
interface hazard_forward_unit_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              two_src;
  logic [ADDR_W-1:0] exe_dst;
  logic [ADDR_W-1:0] mem_dst;
  logic              exe_wb_en;
  logic              mem_wb_en;
  logic              exe_mem_read;
  logic              fw_en;
  logic              mem_ready;
  logic              branch_taken;
  logic              stall;
  logic              bubble;
  logic              flush;
  logic              freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [15:0]       stall_cycles;

  modport master (
    output src1, src2, two_src, exe_dst, mem_dst, exe_wb_en, mem_wb_en,
           exe_mem_read, fw_en, mem_ready, branch_taken,
    input  stall, bubble, flush, freeze, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  src1, src2, two_src, exe_dst, mem_dst, exe_wb_en, mem_wb_en,
           exe_mem_read, fw_en, mem_ready, branch_taken,
    output stall, bubble, flush, freeze, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// RAW hazard detection and EXE-stage forwarding control for a 5-stage MIPS
// pipeline. Stretches load-use stalls to LOAD_STALL cycles, freezes the
// pipeline while data memory is busy, squashes stalls on taken branches and
// counts stall cycles (saturating at 16 bits).
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - hazard_forward_unit_if.slave (register addresses, status in;
//          stall/bubble/flush/freeze combinational out, fwd_a/fwd_b and
//          stall_cycles registered out)
module hazard_forward_unit #(
  parameter int ADDR_W      = 5,
  parameter int LOAD_STALL  = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // The cycle that detects the load counts as the first stall cycle, and the
  // LOAD_WAIT exit cycle (cnt==0) is the last, hence the -2.
  localparam logic [2:0] CNT_INIT = (LOAD_STALL > 1) ? 3'(LOAD_STALL - 2) : 3'd0;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic m1e, m2e, m1m, m2m;
  logic raw_exe, raw_mem, load_use, hz;
  logic stall, bubble, flush, freeze;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Register match; register 0 is hard-wired so it never matches when enabled.
  function automatic logic reg_match(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d);
    return (s == d) && !((ZERO_REG_EN != 0) && (d == {ADDR_W{1'b0}}));
  endfunction

  // Hazard detection, control outputs and forward selection.
  always_comb begin
    m1e      = reg_match(bus.src1, bus.exe_dst);
    m2e      = bus.two_src && reg_match(bus.src2, bus.exe_dst);
    m1m      = reg_match(bus.src1, bus.mem_dst);
    m2m      = bus.two_src && reg_match(bus.src2, bus.mem_dst);
    raw_exe  = bus.exe_wb_en && (m1e || m2e);
    raw_mem  = bus.mem_wb_en && (m1m || m2m);
    load_use = bus.exe_mem_read && raw_exe;

    if (bus.fw_en) begin
      hz = load_use || (state_q == LOAD_WAIT);
    end else begin
      hz = raw_exe || raw_mem;
    end

    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    freeze = 1'b0;
    if (rst) begin
      freeze = 1'b0;
    end else if (!bus.mem_ready) begin
      freeze = 1'b1;
    end else if (bus.branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      stall  = 1'b0;
    end

    // A load in EXE has no result yet, so it is never an EXE/MEM forward source.
    fwd_a_c = 2'b00;
    if (!bus.fw_en) begin
      fwd_a_c = 2'b00;
    end else if (bus.exe_wb_en && m1e && !bus.exe_mem_read) begin
      fwd_a_c = 2'b01;
    end else if (bus.mem_wb_en && m1m) begin
      fwd_a_c = 2'b10;
    end else begin
      fwd_a_c = 2'b00;
    end

    // m2e/m2m already carry the two_src gate.
    fwd_b_c = 2'b00;
    if (!bus.fw_en) begin
      fwd_b_c = 2'b00;
    end else if (bus.exe_wb_en && m2e && !bus.exe_mem_read) begin
      fwd_b_c = 2'b01;
    end else if (bus.mem_wb_en && m2m) begin
      fwd_b_c = 2'b10;
    end else begin
      fwd_b_c = 2'b00;
    end
  end

  // Next-state logic; everything holds while the pipeline is frozen.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cycles_d = stall_cycles_q;
    if (bus.mem_ready) begin
      if (bus.branch_taken) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.fw_en && load_use && (LOAD_STALL > 1)) begin
              state_d = LOAD_WAIT;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = IDLE;
            end
          end
          LOAD_WAIT: begin
            if (cnt_q == 3'd0) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end
        endcase
      end
      fwd_a_d = bubble ? 2'b00 : fwd_a_c;
      fwd_b_d = bubble ? 2'b00 : fwd_b_c;
      if (stall && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.bubble       = bubble;
  assign bus.flush        = flush;
  assign bus.freeze       = freeze;
  assign bus.fwd_a        = fwd_a_q;
  assign bus.fwd_b        = fwd_b_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: two instances (LOAD_STALL=3 and 4) share
// one stimulus; directed scenarios plus randomized traffic checked against a
// remaining-stall-cycles reference model.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] src1, src2, exe_dst, mem_dst;
  logic       two_src, exe_wb_en, mem_wb_en, exe_mem_read, fw_en, mem_ready, branch_taken;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit_if #(.ADDR_W(5)) if_a ();
  hazard_forward_unit_if #(.ADDR_W(5)) if_b ();

  assign if_a.src1 = src1;             assign if_b.src1 = src1;
  assign if_a.src2 = src2;             assign if_b.src2 = src2;
  assign if_a.two_src = two_src;       assign if_b.two_src = two_src;
  assign if_a.exe_dst = exe_dst;       assign if_b.exe_dst = exe_dst;
  assign if_a.mem_dst = mem_dst;       assign if_b.mem_dst = mem_dst;
  assign if_a.exe_wb_en = exe_wb_en;   assign if_b.exe_wb_en = exe_wb_en;
  assign if_a.mem_wb_en = mem_wb_en;   assign if_b.mem_wb_en = mem_wb_en;
  assign if_a.exe_mem_read = exe_mem_read; assign if_b.exe_mem_read = exe_mem_read;
  assign if_a.fw_en = fw_en;           assign if_b.fw_en = fw_en;
  assign if_a.mem_ready = mem_ready;   assign if_b.mem_ready = mem_ready;
  assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;

  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(3), .ZERO_REG_EN(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(4), .ZERO_REG_EN(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // Reference model: pend = stall cycles still owed to an accepted load-use.
  int         pend [2];
  logic [1:0] mfa  [2];
  logic [1:0] mfb  [2];
  int         msc  [2];

  function automatic int ls_of(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic logic mm(input logic [4:0] s, input logic [4:0] d);
    return (s == d) && (d != 5'd0);
  endfunction

  task automatic model_eval(input int k, output logic e_st, output logic e_bu,
                            output logic e_fl, output logic e_fr, output logic lu,
                            output logic [1:0] c_fa, output logic [1:0] c_fb);
    logic m1e, m2e, m1m, m2m, rawe, rawm, hz;
    m1e  = mm(src1, exe_dst);
    m2e  = two_src && mm(src2, exe_dst);
    m1m  = mm(src1, mem_dst);
    m2m  = two_src && mm(src2, mem_dst);
    rawe = exe_wb_en && (m1e || m2e);
    rawm = mem_wb_en && (m1m || m2m);
    lu   = exe_mem_read && rawe;
    hz   = fw_en ? (lu || pend[k] > 0) : (rawe || rawm);
    e_st = 1'b0; e_bu = 1'b0; e_fl = 1'b0; e_fr = 1'b0;
    if (rst) begin
      e_st = 1'b0;
    end else if (!mem_ready) begin
      e_fr = 1'b1;
    end else if (branch_taken) begin
      e_fl = 1'b1; e_bu = 1'b1;
    end else if (hz) begin
      e_st = 1'b1; e_bu = 1'b1;
    end
    c_fa = 2'b00;
    c_fb = 2'b00;
    if (fw_en) begin
      if (exe_wb_en && m1e && !exe_mem_read) c_fa = 2'b01;
      else if (mem_wb_en && m1m)             c_fa = 2'b10;
      if (exe_wb_en && m2e && !exe_mem_read) c_fb = 2'b01;
      else if (mem_wb_en && m2m)             c_fb = 2'b10;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; mfa[k] = 2'b00; mfb[k] = 2'b00; msc[k] = 0;
    end
  endtask

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic st, bu, fl, fr, lu;
    logic [1:0] ca, cb;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, st, bu, fl, fr, lu, ca, cb);
      if (!rst && mem_ready) begin
        if (branch_taken)                         pend[k] = 0;
        else if (pend[k] > 0)                     pend[k] = pend[k] - 1;
        else if (fw_en && lu && ls_of(k) > 1)     pend[k] = ls_of(k) - 1;
        mfa[k] = bu ? 2'b00 : ca;
        mfb[k] = bu ? 2'b00 : cb;
        if (st && msc[k] < 65535) msc[k] = msc[k] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    src1 = 5'd0; src2 = 5'd0; exe_dst = 5'd0; mem_dst = 5'd0;
    two_src = 1'b1; exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_mem_read = 1'b0;
    fw_en = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    #1;
  endtask

  task automatic load_r5();
    fw_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dst = 5'd5;
    src2 = 5'd5; two_src = 1'b1; src1 = 5'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    set_idle();
    fw_en = 1'b0; src1 = 5'd3; exe_dst = 5'd3; exe_wb_en = 1'b1; mem_ready = 1'b0;
    #1;
    total++; if (if_a.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", if_a.stall); end
    total++; if (if_a.freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze: got %b want 0", if_a.freeze); end
    total++; if (if_a.fwd_a !== 2'b00 || if_b.fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd: got %b/%b want 00", if_a.fwd_a, if_b.fwd_b); end
    total++; if (if_a.stall_cycles !== 16'd0 || if_b.stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0", if_a.stall_cycles, if_b.stall_cycles); end
    do_reset();
  endtask

  task automatic test_no_fw_raw();
    set_idle();
    fw_en = 1'b0; src1 = 5'd3; exe_dst = 5'd3; exe_wb_en = 1'b1;
    #1;
    total++; if (if_a.stall !== 1'b1 || if_a.bubble !== 1'b1) begin bad++; $display("FAIL nofw_raw: got stall=%b bubble=%b want 1/1", if_a.stall, if_a.bubble); end
    src1 = 5'd0; exe_dst = 5'd0;
    #1;
    total++; if (if_a.stall !== 1'b0) begin bad++; $display("FAIL nofw_r0: got %b want 0", if_a.stall); end
    src1 = 5'd2; src2 = 5'd7; exe_dst = 5'd7; two_src = 1'b0;
    #1;
    total++; if (if_a.stall !== 1'b0) begin bad++; $display("FAIL nofw_imm: got %b want 0", if_a.stall); end
    do_reset();
  endtask

  task automatic test_load_use();
    load_r5();
    #1;
    for (int i = 0; i < 6; i++) begin
      total++; if (if_a.stall !== (i < 3)) begin bad++; $display("FAIL load_use_a[%0d]: got %b want %b", i, if_a.stall, (i < 3)); end
      total++; if (if_b.stall !== (i < 4)) begin bad++; $display("FAIL load_use_b[%0d]: got %b want %b", i, if_b.stall, (i < 4)); end
      tick();
      exe_mem_read = 1'b0; exe_wb_en = 1'b0;
    end
    total++; if (if_a.stall_cycles !== 16'd3) begin bad++; $display("FAIL load_cnt_a: got %0d want 3", if_a.stall_cycles); end
    total++; if (if_b.stall_cycles !== 16'd4) begin bad++; $display("FAIL load_cnt_b: got %0d want 4", if_b.stall_cycles); end
    do_reset();
  endtask

  task automatic test_forward();
    set_idle();
    exe_dst = 5'd4; mem_dst = 5'd4; exe_wb_en = 1'b1; mem_wb_en = 1'b1; src1 = 5'd4; src2 = 5'd9;
    #1;
    total++; if (if_a.stall !== 1'b0) begin bad++; $display("FAIL fwd_nostall: got %b want 0", if_a.stall); end
    tick();
    total++; if (if_a.fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_exe: got %b want 01", if_a.fwd_a); end
    exe_wb_en = 1'b0;
    tick();
    total++; if (if_a.fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_mem: got %b want 10", if_a.fwd_a); end
    exe_wb_en = 1'b1; exe_dst = 5'd7; src2 = 5'd7; two_src = 1'b0;
    tick();
    total++; if (if_a.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_imm_b: got %b want 00", if_a.fwd_b); end
    two_src = 1'b1;
    tick();
    total++; if (if_a.fwd_b !== 2'b01) begin bad++; $display("FAIL fwd_b_exe: got %b want 01", if_a.fwd_b); end
    fw_en = 1'b0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    tick();
    total++; if (if_a.fwd_b !== 2'b00 || if_a.fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_off: got %b/%b want 00", if_a.fwd_a, if_a.fwd_b); end
    do_reset();
  endtask

  task automatic test_branch();
    load_r5();
    #1;
    tick();
    exe_mem_read = 1'b0; exe_wb_en = 1'b0;
    #1;
    total++; if (if_b.stall !== 1'b1) begin bad++; $display("FAIL br_pre: got %b want 1", if_b.stall); end
    branch_taken = 1'b1;
    #1;
    total++; if (if_b.flush !== 1'b1 || if_b.stall !== 1'b0 || if_b.bubble !== 1'b1) begin bad++; $display("FAIL br_squash: got fl=%b st=%b bu=%b want 1/0/1", if_b.flush, if_b.stall, if_b.bubble); end
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (if_b.stall !== 1'b0 || if_a.stall !== 1'b0) begin bad++; $display("FAIL br_idle: got %b/%b want 0", if_a.stall, if_b.stall); end
    total++; if (if_b.stall_cycles !== 16'd1) begin bad++; $display("FAIL br_cnt: got %0d want 1", if_b.stall_cycles); end
    do_reset();
    load_r5();
    branch_taken = 1'b1;
    #1;
    total++; if (if_a.stall !== 1'b0 || if_a.flush !== 1'b1) begin bad++; $display("FAIL br_same: got st=%b fl=%b want 0/1", if_a.stall, if_a.flush); end
    tick();
    branch_taken = 1'b0; exe_mem_read = 1'b0; exe_wb_en = 1'b0;
    #1;
    total++; if (if_a.stall !== 1'b0 || if_a.stall_cycles !== 16'd0) begin bad++; $display("FAIL br_same_after: got st=%b cnt=%0d want 0/0", if_a.stall, if_a.stall_cycles); end
    do_reset();
  endtask

  task automatic test_freeze();
    int na, nb;
    load_r5();
    #1;
    tick();
    exe_mem_read = 1'b0; exe_wb_en = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (if_a.freeze !== 1'b1 || if_a.stall !== 1'b0 || if_b.stall !== 1'b0) begin bad++; $display("FAIL frz[%0d]: got fr=%b st=%b/%b want 1/0/0", i, if_a.freeze, if_a.stall, if_b.stall); end
      tick();
    end
    mem_ready = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (if_a.stall === 1'b1) na++;
      if (if_b.stall === 1'b1) nb++;
      tick();
    end
    total++; if (na != 2 || nb != 3) begin bad++; $display("FAIL frz_resume: got %0d/%0d want 2/3", na, nb); end
    total++; if (if_a.stall_cycles !== 16'd3 || if_b.stall_cycles !== 16'd4) begin bad++; $display("FAIL frz_cnt: got %0d/%0d want 3/4", if_a.stall_cycles, if_b.stall_cycles); end
    do_reset();
  endtask

  task automatic test_async_reset();
    load_r5();
    #1;
    tick();
    exe_mem_read = 1'b0; exe_wb_en = 1'b0;
    #1;
    total++; if (if_a.stall !== 1'b1) begin bad++; $display("FAIL arst_pre: got %b want 1", if_a.stall); end
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (if_a.stall !== 1'b0 || if_a.stall_cycles !== 16'd0) begin bad++; $display("FAIL arst_now: got st=%b cnt=%0d want 0/0", if_a.stall, if_a.stall_cycles); end
    rst = 1'b0;
    #1;
    total++; if (if_a.stall !== 1'b0 || if_b.stall !== 1'b0) begin bad++; $display("FAIL arst_idle: got %b/%b want 0", if_a.stall, if_b.stall); end
    tick();
    do_reset();
  endtask

  task automatic test_random();
    logic st, bu, fl, fr, lu;
    logic [1:0] ca, cb;
    logic o_st, o_bu, o_fl, o_fr;
    logic [1:0] o_fa, o_fb;
    logic [15:0] o_sc;
    for (int c = 0; c < 600; c++) begin
      src1 = 5'($urandom_range(0, 3)); src2 = 5'($urandom_range(0, 3));
      exe_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3));
      two_src = 1'($urandom_range(0, 1)); exe_wb_en = 1'($urandom_range(0, 1));
      mem_wb_en = 1'($urandom_range(0, 1)); exe_mem_read = ($urandom_range(0, 2) == 0);
      fw_en = ($urandom_range(0, 3) != 0); mem_ready = ($urandom_range(0, 7) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        model_eval(k, st, bu, fl, fr, lu, ca, cb);
        o_st = (k == 0) ? if_a.stall  : if_b.stall;
        o_bu = (k == 0) ? if_a.bubble : if_b.bubble;
        o_fl = (k == 0) ? if_a.flush  : if_b.flush;
        o_fr = (k == 0) ? if_a.freeze : if_b.freeze;
        o_fa = (k == 0) ? if_a.fwd_a  : if_b.fwd_a;
        o_fb = (k == 0) ? if_a.fwd_b  : if_b.fwd_b;
        o_sc = (k == 0) ? if_a.stall_cycles : if_b.stall_cycles;
        total++; if ({o_st, o_bu, o_fl, o_fr} !== {st, bu, fl, fr}) begin bad++; $display("FAIL rnd_ctl c=%0d k=%0d: got %b want %b", c, k, {o_st, o_bu, o_fl, o_fr}, {st, bu, fl, fr}); end
        total++; if ({o_fa, o_fb} !== {mfa[k], mfb[k]}) begin bad++; $display("FAIL rnd_fwd c=%0d k=%0d: got %b want %b", c, k, {o_fa, o_fb}, {mfa[k], mfb[k]}); end
        total++; if (o_sc !== 16'(msc[k])) begin bad++; $display("FAIL rnd_cnt c=%0d k=%0d: got %0d want %0d", c, k, o_sc, msc[k]); end
      end
      tick();
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_no_fw_raw();
    test_load_use();
    test_forward();
    test_branch();
    test_freeze();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
